// File: rtl/mnist_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
// Shared definitions for the MNIST accelerator datapath and its downstream
// result stages.
//   NUM_CLASSES : number of class scores produced by the accelerator (10)
//   IDX_W       : width of a class index (4 bits covers 0..9)
//   LAST_IDX    : index of the final class
//   DATA_W_DEF  : default score width, shared with the accelerator
//   state_t     : sequencing states of the result_argmax block
// -----------------------------------------------------------------------------
package mnist_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam int DATA_W_DEF  = 32;

    localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // True when the given class index is the final class.
    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/result_argmax.sv
// -----------------------------------------------------------------------------
// result_argmax
// Snapshots the ten class scores on each rising edge of the accelerator's
// ready level, scans them one per cycle for the largest signed value, holds
// the winning digit for the CPU and optionally streams the snapshot out one
// score per valid/ready handshake.
//
// Parameters
//   DATA_W      : score width (two's complement)
//   STREAM_EN   : 0 skips the stream phase (scan goes straight to DONE)
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   ready       : accelerator done level; a rising edge means new scores
//   result0..9  : class scores, sampled only in the capture cycle
//   busy        : high while scanning or streaming
//   digit       : winning class index
//   max_score   : score of the winning class
//   digit_valid : digit/max_score valid, held until the next capture
//   out_valid   : stream word valid
//   out_ready   : stream consumer accept
//   out_data    : streamed score
//   out_index   : class index of out_data
//   out_last    : high with index 9
//   overrun     : sticky, a ready rise arrived while busy and was dropped
// -----------------------------------------------------------------------------
module result_argmax
    import mnist_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit STREAM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATA_W-1:0] result0,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    input  logic [DATA_W-1:0] result4,
    input  logic [DATA_W-1:0] result5,
    input  logic [DATA_W-1:0] result6,
    input  logic [DATA_W-1:0] result7,
    input  logic [DATA_W-1:0] result8,
    input  logic [DATA_W-1:0] result9,
    output logic              busy,
    output logic [IDX_W-1:0]  digit,
    output logic [DATA_W-1:0] max_score,
    output logic              digit_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              overrun
);

    state_t             r_state;
    logic               r_ready_q;
    logic [DATA_W-1:0]  r_scores [NUM_CLASSES];
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_best_idx;
    logic [DATA_W-1:0]  r_best_val;
    logic [IDX_W-1:0]   r_sidx;

    logic               r_busy;
    logic [IDX_W-1:0]   r_digit;
    logic [DATA_W-1:0]  r_max_score;
    logic               r_digit_valid;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_last;
    logic               r_overrun;

    logic               w_rise;
    logic               w_gt;
    logic [IDX_W-1:0]   w_next_best_idx;
    logic [DATA_W-1:0]  w_next_best_val;
    logic               w_accept;
    logic [IDX_W-1:0]   w_sidx_next;

    // Rising-edge detect on ready; r_ready_q resets low so a ready already
    // high at reset release is treated as a fresh rise.
    assign w_rise = ready & ~r_ready_q;

    // Scan comparator and stream advance logic.
    always_comb begin
        w_gt            = 1'b0;
        w_next_best_idx = r_best_idx;
        w_next_best_val = r_best_val;
        w_accept        = r_out_valid & out_ready;
        w_sidx_next     = r_sidx + 4'd1;
        // Strict compare: equal scores keep the earlier (lower) index.
        if ($signed(r_scores[r_idx]) > $signed(r_best_val)) begin
            w_gt            = 1'b1;
            w_next_best_idx = r_idx;
            w_next_best_val = r_scores[r_idx];
        end else begin
            w_gt            = 1'b0;
        end
    end

    // Sequencer: capture, scan, stream and hold, with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_ready_q     <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_scores[i] <= '0;
            end
            r_idx         <= 4'd0;
            r_best_idx    <= 4'd0;
            r_best_val    <= '0;
            r_sidx        <= 4'd0;
            r_busy        <= 1'b0;
            r_digit       <= 4'd0;
            r_max_score   <= '0;
            r_digit_valid <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_ready_q <= ready;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_rise) begin
                        r_scores[0]   <= result0;
                        r_scores[1]   <= result1;
                        r_scores[2]   <= result2;
                        r_scores[3]   <= result3;
                        r_scores[4]   <= result4;
                        r_scores[5]   <= result5;
                        r_scores[6]   <= result6;
                        r_scores[7]   <= result7;
                        r_scores[8]   <= result8;
                        r_scores[9]   <= result9;
                        // Class 0 seeds the running maximum, scan starts at 1.
                        r_best_idx    <= 4'd0;
                        r_best_val    <= result0;
                        r_idx         <= 4'd1;
                        r_digit_valid <= 1'b0;
                        r_overrun     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_SCAN;
                    end else begin
                        r_state       <= r_state;
                    end
                end

                ST_SCAN: begin
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end
                    r_best_idx <= w_next_best_idx;
                    r_best_val <= w_next_best_val;
                    if (is_last_idx(r_idx)) begin
                        // The final compare result goes straight to the
                        // outputs so digit appears one cycle after the scan.
                        r_digit       <= w_next_best_idx;
                        r_max_score   <= w_next_best_val;
                        r_digit_valid <= 1'b1;
                        r_sidx        <= 4'd0;
                        if (STREAM_EN) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_scores[0];
                            r_out_last  <= 1'b0;
                            r_state     <= ST_STREAM;
                        end else begin
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end

                ST_STREAM: begin
                    if (w_rise) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end
                    // Word registers only move on acceptance, so they stay
                    // stable across consumer stalls.
                    if (w_accept) begin
                        if (is_last_idx(r_sidx)) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_sidx      <= w_sidx_next;
                            r_out_data  <= r_scores[w_sidx_next];
                            r_out_last  <= is_last_idx(w_sidx_next);
                        end
                    end else begin
                        r_sidx <= r_sidx;
                    end
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign digit       = r_digit;
    assign max_score   = r_max_score;
    assign digit_valid = r_digit_valid;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_index   = r_sidx;
    assign out_last    = r_out_last;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_result_argmax.sv
// -----------------------------------------------------------------------------
// tb_result_argmax
// Directed bench for result_argmax. Two instances share the inputs: dut
// streams, dut_ns has the stream phase disabled. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_result_argmax;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] res [10];

    logic        busy, digit_valid, out_valid, out_last, overrun;
    logic [3:0]  digit, out_index;
    logic [31:0] max_score, out_data;

    logic        ns_busy, ns_digit_valid, ns_out_valid, ns_out_last, ns_overrun;
    logic [3:0]  ns_digit, ns_out_index;
    logic [31:0] ns_max_score, ns_out_data;
    logic        ns_ov_seen = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int vec_a [10] = '{0, 5, 3, -2, 9, 1, 9, 0, 0, 4};
    int vec_n [10] = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
    int vec_m [10] = '{32'h8000_0000, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    int vec_c [10] = '{12, 7, -3, 40, 40, 2, 0, 39, 1, -40};

    always #5 clk = ~clk;

    result_argmax #(.DATA_W(32), .STREAM_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
        .result4(res[4]), .result5(res[5]), .result6(res[6]), .result7(res[7]),
        .result8(res[8]), .result9(res[9]),
        .busy(busy), .digit(digit), .max_score(max_score),
        .digit_valid(digit_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .overrun(overrun)
    );

    result_argmax #(.DATA_W(32), .STREAM_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .ready(ready),
        .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
        .result4(res[4]), .result5(res[5]), .result6(res[6]), .result7(res[7]),
        .result8(res[8]), .result9(res[9]),
        .busy(ns_busy), .digit(ns_digit), .max_score(ns_max_score),
        .digit_valid(ns_digit_valid), .out_valid(ns_out_valid), .out_ready(out_ready),
        .out_data(ns_out_data), .out_index(ns_out_index), .out_last(ns_out_last),
        .overrun(ns_overrun)
    );

    // Remember whether the stream-disabled instance ever raised out_valid.
    always @(negedge clk) begin
        if (ns_out_valid === 1'b1) ns_ov_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // From cycle T+1 (first falling edge after the capture edge) to T+10.
    task automatic wait_result(input logic [3:0] exp_d, input int exp_m);
        chk("busy_t1", {31'd0, busy}, 32'd1);
        chk("dv_cleared_t1", {31'd0, digit_valid}, 32'd0);
        chk("overrun_cleared_t1", {31'd0, overrun}, 32'd0);
        repeat (8) @(negedge clk);
        chk("dv_t9", {31'd0, digit_valid}, 32'd0);
        chk("ns_busy_t9", {31'd0, ns_busy}, 32'd1);
        @(negedge clk);
        chk("dv_t10", {31'd0, digit_valid}, 32'd1);
        chk("digit", {28'd0, digit}, {28'd0, exp_d});
        chk("max_score", max_score, exp_m);
        chk("ns_dv_t10", {31'd0, ns_digit_valid}, 32'd1);
        chk("ns_busy_t10", {31'd0, ns_busy}, 32'd0);
        chk("ns_digit", {28'd0, ns_digit}, {28'd0, exp_d});
    endtask

    // Present scores, make a ready rise and follow the scan through T+10.
    task automatic capture(input int v[10], input logic [3:0] exp_d, input int exp_m);
        for (int i = 0; i < 10; i++) res[i] = v[i];
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        wait_result(exp_d, exp_m);
    endtask

    // Consume the stream; toggle=1 drives out_ready as 1,0,0,1,0,0,...
    task automatic stream(input int v[10], input bit toggle);
        int beats = 0;
        int cyc = 0;
        while (beats < 10 && cyc < 60) begin
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            chk("s_valid", {31'd0, out_valid}, 32'd1);
            chk("s_index", {28'd0, out_index}, beats);
            chk("s_data", out_data, v[beats]);
            chk("s_last", {31'd0, out_last}, (beats == 9) ? 32'd1 : 32'd0);
            if (out_ready) beats++;
            cyc++;
            @(negedge clk);
        end
        chk("s_beats", beats, 32'd10);
        chk("s_end_valid", {31'd0, out_valid}, 32'd0);
        chk("s_end_busy", {31'd0, busy}, 32'd0);
        chk("s_end_dv", {31'd0, digit_valid}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) res[i] = 32'd0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dv", {31'd0, digit_valid}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_digit", {28'd0, digit}, 32'd0);
        chk("rst_max", max_score, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic argmax with a tie at index 6, full-rate stream.
        capture(vec_a, 4'd4, 9);
        stream(vec_a, 1'b0);

        // Signed compare over all-negative scores, stalled stream.
        capture(vec_n, 4'd9, -91);
        stream(vec_n, 1'b1);

        // Most negative value at index 0; equal scores keep index 1.
        out_ready = 1'b0;
        capture(vec_m, 4'd1, -7);
        // Rise during the stream is dropped and flagged.
        for (int i = 0; i < 10; i++) res[i] = vec_c[i];
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("overrun_busy", {31'd0, busy}, 32'd1);
        chk("overrun_hold_data", out_data, vec_m[0]);
        stream(vec_m, 1'b1);
        chk("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Recapture from DONE clears overrun.
        capture(vec_c, 4'd3, 40);
        stream(vec_c, 1'b0);

        // Reset in the middle of a scan.
        for (int i = 0; i < 10; i++) res[i] = vec_a[i];
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_dv", {31'd0, digit_valid}, 32'd0);
        chk("mid_rst_digit", {28'd0, digit}, 32'd0);
        chk("mid_rst_max", max_score, 32'd0);
        chk("mid_rst_idx", {28'd0, out_index}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) res[i] = vec_n[i];
        reset = 1'b1;
        // ready is still high: the first edge after release captures.
        @(negedge clk);
        wait_result(4'd9, -91);
        stream(vec_n, 1'b0);

        chk("ns_never_valid", {31'd0, ns_ov_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_argmax.md
# result_argmax

Downstream stage of the NN accelerator: it consumes the ten signed 32-bit class scores `result0`..`result9` together with the accelerator's `ready` level. On each rising edge of `ready` it snapshots all ten scores and scans them sequentially to find the winning digit. It then streams the ten snapshotted scores one per handshake to the picoRV32-side bus logic. The classified digit is held stable for the CPU until the next capture.

## Interface
- `DATA_W`, 32, score width; scores are two's-complement signed.
- `STREAM_EN`, 1, when 0 the STREAM state is skipped (SCAN goes directly to DONE).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ready`  in  1  accelerator done level; a rising edge means new scores are valid.
- `result0`..`result9`  in  DATA_W each  class scores, sampled only in the capture cycle.
- `busy`  out  1  high in SCAN and STREAM.
- `digit`  out  4  argmax index, 0..9.
- `max_score`  out  DATA_W  score of `digit`.
- `digit_valid`  out  1  `digit`/`max_score` valid; held until the next capture.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream consumer accept.
- `out_data`  out  DATA_W  streamed score.
- `out_index`  out  4  class index of `out_data`.
- `out_last`  out  1  high with index 9.
- `overrun`  out  1  sticky: a `ready` rising edge was dropped.

## Operation
- Edge detect: `ready_q` is a register of `ready`. A rise is `ready & ~ready_q`. `ready_q` resets to 0, so a `ready` that is high when reset releases counts as a rise.
- States: IDLE, SCAN, STREAM, DONE.
- IDLE/DONE + rise: latch `result0..9` into `scores[0..9]`. Set best_idx=0, best_val=`result0`, idx=1, clear `digit_valid`, clear `overrun`. Go to SCAN.
- SCAN: each cycle, if `$signed(scores[idx]) > $signed(best_val)`, set best_idx=idx and best_val=scores[idx]. The comparison is strict, so a tie keeps the lower index. Increment idx.
  - When idx=9 is processed: update `digit`/`max_score` with the final result, set `digit_valid`, set sidx=0. Go to STREAM, or to DONE if `STREAM_EN`=0.
- STREAM: `out_valid`=1, `out_data`=scores[sidx], `out_index`=sidx, `out_last`=(sidx==9).
  - On `out_valid & out_ready`, increment sidx.
  - On acceptance of sidx=9, go to DONE.
  - `out_data`, `out_index` and `out_last` stay stable while `out_valid & ~out_ready`.
- DONE: outputs hold. A rise restarts capture, as described for IDLE.
- A rise in SCAN or STREAM is ignored: `overrun` is set, and the scores, scan and stream are unaffected.
- Reset mid-operation returns to IDLE immediately; any partial stream is abandoned.

## Timing
- Reset values: state=IDLE; `busy`, `digit_valid`, `out_valid`, `out_last` and `overrun` = 0; `digit`, `max_score`, `out_data` and `out_index` = 0; `ready_q`=0.
- The rise is seen in cycle T, and the scores are captured at the edge closing T.
- SCAN occupies cycles T+1..T+9, with `busy`=1.
- `digit_valid` and `out_valid` first become high in cycle T+10, so latency from rise to digit is 10 cycles.
- With `out_ready` held high, the stream takes 10 cycles (T+10..T+19) and DONE is reached in T+20.
- All outputs are registered; there is no combinational path from input to output except none.

## Structure
- The shared package `mnist_pkg` holds:
  - `NUM_CLASSES`=10 and `IDX_W`=4;
  - the state enum {IDLE, SCAN, STREAM, DONE};
  - the `DATA_W` default, shared with the accelerator.
- No sub-module: the comparator and stream mux are small enough to stay in this block.

## Test plan
- Scores 0,5,3,−2,9,1,9,0,0,4 with a `ready` rise → `digit`=4, `max_score`=9 in cycle T+10; tie with index 6 resolves to the lower index.
- All scores negative (−100..−91, ascending by index) → `digit`=9, `max_score`=−91, proving signed compare; 0x80000000 at index 0 never wins.
- Stream with `out_ready` toggling 1,0,0,1… → exactly 10 beats, indices 0..9 in order, data equal to the captured snapshot, `out_last` only on index 9, and data stable across stalls.
- Change `result*` and pulse `ready` again during STREAM → `overrun`=1, stream data unchanged; the next rise in DONE recaptures and clears `overrun`.
- Assert `reset`=0 mid-SCAN → all outputs return to reset values asynchronously; release with `ready` high → capture on the first cycle.
- `STREAM_EN`=0 → `out_valid` is never asserted; DONE is reached in T+10 with the correct `digit`.
